// File: rtl/tone_sequencer.sv
// Step sequencer that plays a table of tone half-periods, one step per
// step_len audio samples, driving the tone generator's mode bits.
module tone_sequencer #(
    parameter int NUM_STEPS = 8,
    parameter int LOOP      = 0,
    localparam int AW       = $clog2(NUM_STEPS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sample_req,
    input  logic          start,
    input  logic          stop,
    input  logic          feedback_en,
    input  logic [15:0]   step_len,
    input  logic          pat_wr,
    input  logic [AW-1:0] pat_addr,
    input  logic [15:0]   pat_data,
    output logic [3:0]    control,
    output logic [15:0]   half_period,
    output logic [AW-1:0] step_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } state_t;

    localparam logic [AW-1:0] LAST_STEP = AW'(NUM_STEPS - 1);

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [AW-1:0] step_d;
    logic [15:0]   hp_d;
    logic [3:0]    ctrl_d;
    logic          busy_d, done_d;

    logic [15:0]   pat_mem [NUM_STEPS];
    logic [15:0]   eff_len;
    logic [15:0]   last_cnt;
    logic [AW-1:0] nxt_step;
    logic [15:0]   nxt_hp;

    assign eff_len  = (step_len == 16'd0) ? 16'd1 : step_len;
    assign last_cnt = eff_len - 16'd1;
    // Power-of-two table: the increment wraps to step 0 by itself.
    assign nxt_step = step_idx + 1'b1;
    assign nxt_hp   = pat_mem[nxt_step];

    // The table is left out of reset so a pattern survives it.
    always_ff @(posedge clk) begin
        if (pat_wr && state_q == IDLE)
            pat_mem[pat_addr] <= pat_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_idx;
        hp_d    = half_period;
        ctrl_d  = control;
        busy_d  = busy;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
            step_d  = '0;
            hp_d    = 16'd0;
            ctrl_d  = 4'd0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d  = 16'd0;
                    step_d = '0;
                    hp_d   = 16'd0;
                    ctrl_d = {2'b00, feedback_en, 1'b0};
                    busy_d = 1'b0;
                    if (start) begin
                        state_d = PLAY;
                        hp_d    = pat_mem[0];
                        ctrl_d  = {3'b000, |pat_mem[0]};
                        busy_d  = 1'b1;
                    end
                end
                PLAY: begin
                    if (sample_req) begin
                        if (cnt_q == last_cnt) begin
                            cnt_d = 16'd0;
                            if (step_idx == LAST_STEP && LOOP == 0) begin
                                state_d = DONE;
                                step_d  = '0;
                                hp_d    = 16'd0;
                                ctrl_d  = 4'd0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                step_d = nxt_step;
                                hp_d   = nxt_hp;
                                ctrl_d = {3'b000, |nxt_hp};
                            end
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                    step_d  = '0;
                    hp_d    = 16'd0;
                    ctrl_d  = {2'b00, feedback_en, 1'b0};
                    busy_d  = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= 16'd0;
            step_idx    <= '0;
            half_period <= 16'd0;
            control     <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            step_idx    <= step_d;
            half_period <= hp_d;
            control     <= ctrl_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: a stopping instance and a looping
// instance share all inputs; expected values are hand-derived.
module tb_tone_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_req = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        feedback_en = 1'b0;
    logic [15:0] step_len = 16'd3;
    logic        pat_wr = 1'b0;
    logic [2:0]  pat_addr = 3'd0;
    logic [15:0] pat_data = 16'd0;

    logic [3:0]  control0, control1;
    logic [15:0] hp0, hp1;
    logic [2:0]  step0, step1;
    logic        busy0, busy1, done0, done1;

    int total = 0;
    int bad = 0;

    logic [15:0] tbl [8] = '{16'd100, 16'd0, 16'd200, 16'd50,
                             16'd300, 16'd0, 16'd400, 16'd500};

    always #5 clk = ~clk;

    tone_sequencer #(.NUM_STEPS(8), .LOOP(0)) dut0 (
        .clk(clk), .reset(reset), .sample_req(sample_req),
        .start(start), .stop(stop), .feedback_en(feedback_en),
        .step_len(step_len), .pat_wr(pat_wr), .pat_addr(pat_addr),
        .pat_data(pat_data), .control(control0), .half_period(hp0),
        .step_idx(step0), .busy(busy0), .done(done0)
    );

    tone_sequencer #(.NUM_STEPS(8), .LOOP(1)) dut1 (
        .clk(clk), .reset(reset), .sample_req(sample_req),
        .start(start), .stop(stop), .feedback_en(feedback_en),
        .step_len(step_len), .pat_wr(pat_wr), .pat_addr(pat_addr),
        .pat_data(pat_data), .control(control1), .half_period(hp1),
        .step_idx(step1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_sample();
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic chk0(input string tag, input logic [2:0] s,
                        input logic [15:0] hp, input logic [3:0] c,
                        input logic b, input logic d);
        chk({tag, ".step"}, 32'(step0), 32'(s));
        chk({tag, ".hp"}, 32'(hp0), 32'(hp));
        chk({tag, ".ctrl"}, 32'(control0), 32'(c));
        chk({tag, ".busy"}, 32'(busy0), 32'(b));
        chk({tag, ".done"}, 32'(done0), 32'(d));
    endtask

    initial begin
        @(negedge clk);
        chk0("reset", 3'd0, 16'd0, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk0("idle", 3'd0, 16'd0, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            pat_wr = 1'b1;
            pat_addr = 3'(i);
            pat_data = tbl[i];
            tick();
        end
        pat_wr = 1'b0;

        // start with a coincident sample_req that must not count
        step_len = 16'd3;
        sample_req = 1'b1;
        pulse_start();
        sample_req = 1'b0;
        chk0("start", 3'd0, 16'd100, 4'd1, 1'b1, 1'b0);
        pulse_sample();
        pulse_sample();
        chk0("s0_hold", 3'd0, 16'd100, 4'd1, 1'b1, 1'b0);
        pulse_sample();
        chk0("s1_rest", 3'd1, 16'd0, 4'd0, 1'b1, 1'b0);

        pat_wr = 1'b1;
        pat_addr = 3'd0;
        pat_data = 16'd999;
        tick();
        pat_wr = 1'b0;

        pulse_sample();
        pulse_sample();
        chk0("s1_hold", 3'd1, 16'd0, 4'd0, 1'b1, 1'b0);
        pulse_sample();
        chk0("s2", 3'd2, 16'd200, 4'd1, 1'b1, 1'b0);
        repeat (3) pulse_sample();
        chk0("s3", 3'd3, 16'd50, 4'd1, 1'b1, 1'b0);

        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        chk0("stop", 3'd0, 16'd0, 4'd0, 1'b0, 1'b0);
        tick();
        chk0("stop_idle", 3'd0, 16'd0, 4'd0, 1'b0, 1'b0);

        step_len = 16'd1;
        pulse_start();
        chk0("restart", 3'd0, 16'd100, 4'd1, 1'b1, 1'b0);
        repeat (7) pulse_sample();
        chk0("s7", 3'd7, 16'd500, 4'd1, 1'b1, 1'b0);
        chk("loop.s7", 32'(step1), 32'd7);
        pulse_sample();
        chk0("done", 3'd0, 16'd0, 4'd0, 1'b0, 1'b1);
        chk("loop.step", 32'(step1), 32'd0);
        chk("loop.hp", 32'(hp1), 32'd100);
        chk("loop.busy", 32'(busy1), 32'd1);
        chk("loop.done", 32'(done1), 32'd0);
        tick();
        chk0("after_done", 3'd0, 16'd0, 4'd0, 1'b0, 1'b0);
        chk("loop.done2", 32'(done1), 32'd0);

        pulse_stop();
        chk("loop.stop", 32'(busy1), 32'd0);
        step_len = 16'd0;
        pulse_start();
        chk0("len0", 3'd0, 16'd100, 4'd1, 1'b1, 1'b0);
        pulse_sample();
        chk0("len0_s1", 3'd1, 16'd0, 4'd0, 1'b1, 1'b0);
        pulse_sample();
        chk0("len0_s2", 3'd2, 16'd200, 4'd1, 1'b1, 1'b0);

        // asynchronous reset, checked before the next rising edge
        reset = 1'b1;
        #1;
        chk0("async_rst", 3'd0, 16'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        feedback_en = 1'b1;
        tick();
        chk("fb.ctrl", 32'(control0), 32'd2);
        feedback_en = 1'b0;
        tick();
        chk("fb.off", 32'(control0), 32'd0);
        pulse_start();
        chk("tbl_kept", 32'(hp0), 32'd100);
        pulse_stop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
